// File: rtl/bank_scheduler_pkg.sv
// Shared types and constants for the per-bank traffic scheduler.
//   - NODES_PER_BANK / MAX_PATHS_BITS: bank sizing and result width.
//   - pkt_t: mesh packet (ctrl, x/y/z address, sum payload, source tag).
//   - rr_grant_t: round-robin grant (valid + node index).
package bank_scheduler_pkg;

  localparam int unsigned NODES_PER_BANK = 4;
  localparam int unsigned MAX_PATHS_BITS = 16;
  localparam int unsigned ADDR_Z_BITS    = 4;
  localparam int unsigned GRANT_IDX_BITS = $clog2(NODES_PER_BANK);

  typedef enum logic [1:0] {
    CTRL_DATA = 2'd0,
    CTRL_DONE = 2'd1,
    CTRL_CFG  = 2'd2,
    CTRL_NOP  = 2'd3
  } ctrl_e;

  typedef struct packed {
    logic [3:0]             x;
    logic [3:0]             y;
    logic [ADDR_Z_BITS-1:0] z;
  } addr_t;

  typedef struct packed {
    logic [MAX_PATHS_BITS-1:0] value;
  } sum_t;

  typedef struct packed {
    ctrl_e      ctrl;
    addr_t      addr;
    sum_t       sum;
    logic [7:0] src;
  } pkt_t;

  typedef struct packed {
    logic                      valid;
    logic [GRANT_IDX_BITS-1:0] idx;
  } rr_grant_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   en        : grant enable (no grant when low)
//   ptr       : highest-priority index; search wraps modulo N
//   gnt       : one-hot grant (or zero)
//   gnt_idx   : index of the granted requester
//   gnt_valid : a grant was issued
// The pointer register is owned by the instantiating block.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic            en,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx,
  output logic            gnt_valid
);

  always_comb begin
    int unsigned cand;
    cand      = 0;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = (32'(ptr) + off) % N;
      if (en && !gnt_valid && req[IdxW'(cand)]) begin
        gnt_valid          = 1'b1;
        gnt_idx            = IdxW'(cand);
        gnt[IdxW'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_scheduler.sv
// Per-bank traffic scheduler between the bank's nodes and its mesh router port.
//   node_valid_out/node_pkt_out/node_ready_out : node egress, round-robin arbitrated
//   node_valid_in/node_pkt_in/node_ready_in    : node ingress, steered by addr.z
//   net_tx_*                                   : registered transmit stream to router
//   net_rx_*                                   : receive stream from router
//   done/done_value                            : first CTRL_DONE result (sticky)
//   addr_err                                   : sticky, ingress addr.z out of range
module bank_scheduler
  import bank_scheduler_pkg::*;
#(
  parameter int unsigned N_NODES = NODES_PER_BANK,
  parameter int unsigned Z_BITS  = $clog2(N_NODES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_NODES-1:0]        node_valid_out,
  input  pkt_t                      node_pkt_out [N_NODES],
  output logic [N_NODES-1:0]        node_ready_out,
  output logic [N_NODES-1:0]        node_valid_in,
  output pkt_t                      node_pkt_in,
  input  logic [N_NODES-1:0]        node_ready_in,
  output logic                      net_tx_valid,
  input  logic                      net_tx_ready,
  output pkt_t                      net_tx_pkt,
  input  logic                      net_rx_valid,
  output logic                      net_rx_ready,
  input  pkt_t                      net_rx_pkt,
  output logic                      done,
  output logic [MAX_PATHS_BITS-1:0] done_value,
  output logic                      addr_err
);

  logic [Z_BITS-1:0]         rr_ptr_d, rr_ptr_q;
  logic                      tx_full_d, tx_full_q;
  pkt_t                      tx_pkt_d, tx_pkt_q;
  logic                      rx_full_d, rx_full_q;
  pkt_t                      rx_pkt_d, rx_pkt_q;
  logic                      done_d, done_q;
  logic [MAX_PATHS_BITS-1:0] done_value_d, done_value_q;
  logic                      addr_err_d, addr_err_q;

  logic              can_accept;
  logic [Z_BITS-1:0] gnt_idx;
  logic              gnt_valid;
  rr_grant_t         grant;
  pkt_t              acc_pkt;
  logic              rx_drain;
  logic              rx_take;

  // Egress may take a packet when the holding register is empty or draining now.
  assign can_accept = !tx_full_q || net_tx_ready;

  rr_arbiter #(
    .N    (N_NODES),
    .IdxW (Z_BITS)
  ) u_rr_arbiter (
    .req       (node_valid_out),
    .en        (can_accept && !rst),
    .ptr       (rr_ptr_q),
    .gnt       (node_ready_out),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    grant.valid = gnt_valid;
    grant.idx   = gnt_idx;
  end

  assign acc_pkt = node_pkt_out[grant.idx];

  // Egress next state: drain first, then a load in the same cycle overrides it.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    tx_full_d    = tx_full_q;
    tx_pkt_d     = tx_pkt_q;
    done_d       = done_q;
    done_value_d = done_value_q;
    if (tx_full_q && net_tx_ready) begin
      tx_full_d = 1'b0;
    end
    if (grant.valid) begin
      rr_ptr_d = (grant.idx == Z_BITS'(N_NODES - 1)) ? '0 : grant.idx + Z_BITS'(1);
      if (acc_pkt.ctrl == CTRL_DONE) begin
        // Only the first DONE is recorded; later ones are swallowed.
        if (!done_q) begin
          done_d       = 1'b1;
          done_value_d = acc_pkt.sum.value;
        end
      end else begin
        tx_full_d = 1'b1;
        tx_pkt_d  = acc_pkt;
      end
    end
  end

  // Ingress: decode the held packet's z into a one-hot valid and its ready.
  always_comb begin
    rx_drain      = 1'b0;
    node_valid_in = '0;
    for (int unsigned i = 0; i < N_NODES; i++) begin
      if (rx_pkt_q.addr.z == ADDR_Z_BITS'(i)) begin
        node_valid_in[i] = rx_full_q;
        rx_drain         = rx_full_q && node_ready_in[i];
      end
    end
    net_rx_ready = !rx_full_q || rx_drain;
    rx_take      = net_rx_valid && net_rx_ready;

    rx_full_d  = rx_full_q;
    rx_pkt_d   = rx_pkt_q;
    addr_err_d = addr_err_q;
    if (rx_drain) begin
      rx_full_d = 1'b0;
    end
    if (rx_take) begin
      // Out-of-range destinations are consumed but never stored.
      if (32'(net_rx_pkt.addr.z) >= N_NODES) begin
        addr_err_d = 1'b1;
      end else begin
        rx_full_d = 1'b1;
        rx_pkt_d  = net_rx_pkt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      tx_full_q    <= 1'b0;
      rx_full_q    <= 1'b0;
      done_q       <= 1'b0;
      done_value_q <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      tx_full_q    <= tx_full_d;
      rx_full_q    <= rx_full_d;
      done_q       <= done_d;
      done_value_q <= done_value_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Packet payloads need no reset; the full flags qualify them.
  always_ff @(posedge clk) begin
    tx_pkt_q <= tx_pkt_d;
    rx_pkt_q <= rx_pkt_d;
  end

  assign net_tx_valid = tx_full_q;
  assign net_tx_pkt   = tx_pkt_q;
  assign node_pkt_in  = rx_pkt_q;
  assign done         = done_q;
  assign done_value   = done_value_q;
  assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_bank_scheduler.sv
module tb_bank_scheduler;
  import bank_scheduler_pkg::*;

  localparam int N = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [N-1:0]              node_valid_out;
  pkt_t                      node_pkt_out [N];
  logic [N-1:0]              node_ready_out;
  logic [N-1:0]              node_valid_in;
  pkt_t                      node_pkt_in;
  logic [N-1:0]              node_ready_in;
  logic                      net_tx_valid;
  logic                      net_tx_ready;
  pkt_t                      net_tx_pkt;
  logic                      net_rx_valid;
  logic                      net_rx_ready;
  pkt_t                      net_rx_pkt;
  logic                      done;
  logic [MAX_PATHS_BITS-1:0] done_value;
  logic                      addr_err;

  always #5 clk = ~clk;

  bank_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .node_valid_out (node_valid_out),
    .node_pkt_out   (node_pkt_out),
    .node_ready_out (node_ready_out),
    .node_valid_in  (node_valid_in),
    .node_pkt_in    (node_pkt_in),
    .node_ready_in  (node_ready_in),
    .net_tx_valid   (net_tx_valid),
    .net_tx_ready   (net_tx_ready),
    .net_tx_pkt     (net_tx_pkt),
    .net_rx_valid   (net_rx_valid),
    .net_rx_ready   (net_rx_ready),
    .net_rx_pkt     (net_rx_pkt),
    .done           (done),
    .done_value     (done_value),
    .addr_err       (addr_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic pkt_t mk(input ctrl_e c, input int z, input int v, input int src);
    pkt_t p;
    p.ctrl      = c;
    p.addr.x    = 4'd0;
    p.addr.y    = 4'd0;
    p.addr.z    = ADDR_Z_BITS'(z);
    p.sum.value = MAX_PATHS_BITS'(v);
    p.src       = 8'(src);
    return p;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Egress table: applied in order straight after reset; expectations hand-derived.
  typedef struct {
    logic [N-1:0] valid;
    logic         tx_rdy;
    logic [N-1:0] exp_ready_out;
    logic         exp_tx_valid;
    int           exp_src;
  } vec_t;

  vec_t tbl [13];

  // Reference model state for the random phase.
  int        m_ptr;
  bit        m_txf;
  pkt_t      m_txp;
  bit        m_rxf;
  pkt_t      m_rxp;
  bit        m_done;
  logic [MAX_PATHS_BITS-1:0] m_dval;
  bit        m_aerr;

  initial begin
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 3};
    tbl[5]  = '{4'b1010, 1'b0, 4'b0000, 1'b1, 0};
    tbl[6]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 0};
    tbl[7]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 1};
    tbl[8]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 0};
    tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 0};
    tbl[11] = '{4'b1000, 1'b0, 4'b1000, 1'b0, 0};
    tbl[12] = '{4'b1000, 1'b0, 4'b0000, 1'b1, 3};

    rst            = 1'b1;
    node_valid_out = '0;
    node_ready_in  = '0;
    net_tx_ready   = 1'b0;
    net_rx_valid   = 1'b0;
    net_rx_pkt     = mk(CTRL_DATA, 0, 0, 0);
    for (int i = 0; i < N; i++) node_pkt_out[i] = mk(CTRL_DATA, 0, 100 + i, i);
    repeat (2) next_cycle();

    // Reset state
    chk("rst_ready_out", 64'(node_ready_out), 64'(0));
    chk("rst_valid_in", 64'(node_valid_in), 64'(0));
    chk("rst_tx_valid", 64'(net_tx_valid), 64'(0));
    chk("rst_rx_ready", 64'(net_rx_ready), 64'(1));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_done_value", 64'(done_value), 64'(0));
    chk("rst_addr_err", 64'(addr_err), 64'(0));
    rst = 1'b0;

    // Round-robin sweep, back-pressure and wrap via the table
    for (int k = 0; k < 13; k++) begin
      node_valid_out = tbl[k].valid;
      net_tx_ready   = tbl[k].tx_rdy;
      #3;
      chk($sformatf("tbl%0d_ready_out", k), 64'(node_ready_out), 64'(tbl[k].exp_ready_out));
      chk($sformatf("tbl%0d_tx_valid", k), 64'(net_tx_valid), 64'(tbl[k].exp_tx_valid));
      if (tbl[k].exp_tx_valid)
        chk($sformatf("tbl%0d_tx_src", k), 64'(net_tx_pkt.src), 64'(tbl[k].exp_src));
      next_cycle();
    end
    node_valid_out = '0;
    net_tx_ready   = 1'b1;
    next_cycle();
    chk("drain_tx_valid", 64'(net_tx_valid), 64'(0));

    // DONE intercept: first value kept, neither reaches the network
    node_pkt_out[2] = mk(CTRL_DONE, 0, 37, 2);
    node_valid_out  = 4'b0100;
    #3;
    chk("done1_ready_out", 64'(node_ready_out), 64'(4'b0100));
    next_cycle();
    chk("done1_done", 64'(done), 64'(1));
    chk("done1_value", 64'(done_value), 64'(37));
    chk("done1_tx_valid", 64'(net_tx_valid), 64'(0));
    node_pkt_out[2] = mk(CTRL_DONE, 0, 99, 2);
    #3;
    chk("done2_ready_out", 64'(node_ready_out), 64'(4'b0100));
    next_cycle();
    node_valid_out = '0;
    chk("done2_value", 64'(done_value), 64'(37));
    chk("done2_tx_valid", 64'(net_tx_valid), 64'(0));
    node_pkt_out[2] = mk(CTRL_DATA, 0, 102, 2);

    // Ingress steering with node 3 stalled
    node_ready_in = 4'b0111;
    net_rx_valid  = 1'b1;
    net_rx_pkt    = mk(CTRL_DATA, 3, 0, 8'h33);
    #3;
    chk("rx_z3_ready", 64'(net_rx_ready), 64'(1));
    next_cycle();
    net_rx_pkt = mk(CTRL_DATA, 0, 0, 8'h30);
    for (int k = 0; k < 3; k++) begin
      #3;
      chk($sformatf("rx_hold%0d_valid_in", k), 64'(node_valid_in), 64'(4'b1000));
      chk($sformatf("rx_hold%0d_rx_ready", k), 64'(net_rx_ready), 64'(0));
      chk($sformatf("rx_hold%0d_src", k), 64'(node_pkt_in.src), 64'(8'h33));
      next_cycle();
    end
    node_ready_in = 4'b1111;
    #3;
    chk("rx_rel_rx_ready", 64'(net_rx_ready), 64'(1));
    next_cycle();
    net_rx_valid = 1'b0;
    #3;
    chk("rx_z0_valid_in", 64'(node_valid_in), 64'(4'b0001));
    chk("rx_z0_src", 64'(node_pkt_in.src), 64'(8'h30));
    next_cycle();
    chk("rx_empty_valid_in", 64'(node_valid_in), 64'(0));

    // Bad address
    net_rx_valid = 1'b1;
    net_rx_pkt   = mk(CTRL_DATA, 5, 0, 8'h55);
    #3;
    chk("bad_rx_ready", 64'(net_rx_ready), 64'(1));
    next_cycle();
    net_rx_valid = 1'b0;
    chk("bad_addr_err", 64'(addr_err), 64'(1));
    chk("bad_valid_in", 64'(node_valid_in), 64'(0));

    // Reset with both holding registers full
    node_ready_in  = '0;
    net_tx_ready   = 1'b0;
    node_valid_out = 4'b0010;
    net_rx_valid   = 1'b1;
    net_rx_pkt     = mk(CTRL_DATA, 1, 0, 8'h11);
    next_cycle();
    node_valid_out = '0;
    net_rx_valid   = 1'b0;
    chk("pre_rst_tx_valid", 64'(net_tx_valid), 64'(1));
    chk("pre_rst_valid_in", 64'(node_valid_in), 64'(4'b0010));
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    chk("mid_rst_tx_valid", 64'(net_tx_valid), 64'(0));
    chk("mid_rst_valid_in", 64'(node_valid_in), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_addr_err", 64'(addr_err), 64'(0));
    node_valid_out = 4'b1111;
    net_tx_ready   = 1'b1;
    #3;
    chk("mid_rst_first_grant", 64'(node_ready_out), 64'(4'b0001));
    next_cycle();

    // Randomized phase against a reference model, from a clean reset
    node_valid_out = '0;
    net_tx_ready   = 1'b0;
    rst            = 1'b1;
    next_cycle();
    rst    = 1'b0;
    m_ptr  = 0;
    m_txf  = 0;
    m_rxf  = 0;
    m_done = 0;
    m_dval = '0;
    m_aerr = 0;
    m_txp  = mk(CTRL_DATA, 0, 0, 0);
    m_rxp  = mk(CTRL_DATA, 0, 0, 0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      int   g;
      bit   can;
      bit   drain;
      bit   rxrdy;
      pkt_t p;
      node_valid_out = N'($urandom);
      net_tx_ready   = ($urandom_range(0, 3) != 0);
      node_ready_in  = N'($urandom);
      net_rx_valid   = 1'($urandom);
      for (int i = 0; i < N; i++) begin
        node_pkt_out[i] = mk(($urandom_range(0, 7) == 0) ? CTRL_DONE :
                             (($urandom_range(0, 3) == 0) ? CTRL_CFG : CTRL_DATA),
                             $urandom_range(0, 3), $urandom_range(0, 65535), i + 4 * (cyc % 64));
      end
      net_rx_pkt = mk(CTRL_DATA, $urandom_range(0, 5), $urandom_range(0, 65535),
                      $urandom_range(0, 255));
      #3;

      can = !m_txf || net_tx_ready;
      g   = -1;
      if (can) begin
        for (int off = 0; off < N; off++) begin
          if (g < 0 && node_valid_out[(m_ptr + off) % N]) g = (m_ptr + off) % N;
        end
      end
      drain = m_rxf && node_ready_in[m_rxp.addr.z];
      rxrdy = !m_rxf || drain;

      chk("rnd_ready_out", 64'(node_ready_out), (g >= 0) ? (64'(1) << g) : 64'(0));
      chk("rnd_tx_valid", 64'(net_tx_valid), 64'(m_txf));
      if (m_txf) chk("rnd_tx_pkt", 64'(net_tx_pkt), 64'(m_txp));
      chk("rnd_rx_ready", 64'(net_rx_ready), 64'(rxrdy));
      chk("rnd_valid_in", 64'(node_valid_in), m_rxf ? (64'(1) << m_rxp.addr.z) : 64'(0));
      if (m_rxf) chk("rnd_pkt_in", 64'(node_pkt_in), 64'(m_rxp));
      chk("rnd_done", 64'(done), 64'(m_done));
      chk("rnd_done_value", 64'(done_value), 64'(m_dval));
      chk("rnd_addr_err", 64'(addr_err), 64'(m_aerr));

      if (m_txf && net_tx_ready) m_txf = 0;
      if (g >= 0) begin
        p     = node_pkt_out[g];
        m_ptr = (g + 1) % N;
        if (p.ctrl == CTRL_DONE) begin
          if (!m_done) begin
            m_done = 1;
            m_dval = p.sum.value;
          end
        end else begin
          m_txf = 1;
          m_txp = p;
        end
      end
      if (drain) m_rxf = 0;
      if (net_rx_valid && rxrdy) begin
        if (int'(net_rx_pkt.addr.z) >= N) m_aerr = 1;
        else begin
          m_rxf = 1;
          m_rxp = net_rx_pkt;
        end
      end
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
